// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, entry FSM states and display-source encoding.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS = 4'hA;
  localparam logic [3:0] KEY_EQ   = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_BS   = 4'hD;

  // Three BCD digits per operand, so the digit count saturates here.
  localparam logic [1:0] COUNT_MAX = 2'd3;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_SUM = 2'd2;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    RESULT  = 2'd2
  } state_e;

  function automatic logic [1:0] disp_of(state_e s);
    case (s)
      ENTRY_B: return DISP_B;
      RESULT:  return DISP_SUM;
      default: return DISP_A;
    endcase
  endfunction

endpackage

// File: rtl/bcd_operand_reg.sv
// One 3-digit BCD operand with a saturating digit count; shifts left on entry, right on backspace.
module bcd_operand_reg
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_in,
  input  logic [3:0] digit,
  input  logic       shift_out,
  output logic [3:0] dig_1,
  output logic [3:0] dig_2,
  output logic [3:0] dig_3,
  output logic       full
);

  logic [1:0] count;

  assign full = (count == COUNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_1 <= 4'd0;
      dig_2 <= 4'd0;
      dig_3 <= 4'd0;
      count <= 2'd0;
    end else if (clr) begin
      // Clear with a simultaneous digit restarts the operand at that digit.
      dig_1 <= shift_in ? digit : 4'd0;
      dig_2 <= 4'd0;
      dig_3 <= 4'd0;
      count <= shift_in ? 2'd1 : 2'd0;
    end else if (shift_in && !full) begin
      dig_3 <= dig_2;
      dig_2 <= dig_1;
      dig_1 <= digit;
      count <= count + 2'd1;
    end else if (shift_out && (count != 2'd0)) begin
      dig_1 <= dig_2;
      dig_2 <= dig_3;
      dig_3 <= 4'd0;
      count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Keypad-to-operand entry FSM for the BCD calculator; backspace decode only with OPERAND_BACKSPACE_EN defined.
module operand_sequencer
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] dig1_1,
  output logic [3:0] dig1_2,
  output logic [3:0] dig1_3,
  output logic [3:0] dig2_1,
  output logic [3:0] dig2_2,
  output logic [3:0] dig2_3,
  output logic [1:0] disp_sel,
  output logic       sum_start,
  output logic       result_valid
);

  state_e state_q, state_d;
  logic   clr_ops, shift_a, shift_b, bs_a, bs_b, start_d;
  logic   full_a, full_b;
  logic   is_digit;

  assign is_digit = (key_code <= 4'd9);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    clr_ops = 1'b0;
    shift_a = 1'b0;
    shift_b = 1'b0;
    bs_a    = 1'b0;
    bs_b    = 1'b0;
    start_d = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        clr_ops = 1'b1;
        state_d = ENTRY_A;
      end else begin
        case (state_q)
          ENTRY_A: begin
            if (is_digit)                   shift_a = 1'b1;
            else if (key_code == KEY_PLUS)  state_d = ENTRY_B;
`ifdef OPERAND_BACKSPACE_EN
            else if (key_code == KEY_BS)    bs_a = 1'b1;
`endif
          end
          ENTRY_B: begin
            if (is_digit) shift_b = 1'b1;
            else if (key_code == KEY_EQ) begin
              state_d = RESULT;
              start_d = 1'b1;
            end
`ifdef OPERAND_BACKSPACE_EN
            else if (key_code == KEY_BS)    bs_b = 1'b1;
`endif
          end
          RESULT: begin
            // A digit starts a fresh calculation with that digit as A's units.
            if (is_digit) begin
              clr_ops = 1'b1;
              shift_a = 1'b1;
              state_d = ENTRY_A;
            end
          end
          default: state_d = ENTRY_A;
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they line up with the operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENTRY_A;
      disp_sel     <= DISP_A;
      sum_start    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_sel     <= disp_of(state_d);
      sum_start    <= start_d;
      result_valid <= (state_d == RESULT);
    end
  end

  bcd_operand_reg u_op_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_ops),
    .shift_in  (shift_a),
    .digit     (key_code),
    .shift_out (bs_a),
    .dig_1     (dig1_1),
    .dig_2     (dig1_2),
    .dig_3     (dig1_3),
    .full      (full_a)
  );

  bcd_operand_reg u_op_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_ops),
    .shift_in  (shift_b),
    .digit     (key_code),
    .shift_out (bs_b),
    .dig_1     (dig2_1),
    .dig_2     (dig2_2),
    .dig_3     (dig2_3),
    .full      (full_b)
  );

  // Saturation is handled inside each operand; the flags are kept for debug visibility only.
  logic unused_full;
  assign unused_full = full_a ^ full_b;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer; expectations follow OPERAND_BACKSPACE_EN when it is defined.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] dig1_1, dig1_2, dig1_3;
  logic [3:0] dig2_1, dig2_2, dig2_3;
  logic [1:0] disp_sel;
  logic       sum_start;
  logic       result_valid;

  int tests = 0;
  int fails = 0;
  int sum_cnt = 0;
  int sum_base;

  operand_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .dig1_1       (dig1_1),
    .dig1_2       (dig1_2),
    .dig1_3       (dig1_3),
    .dig2_1       (dig2_1),
    .dig2_2       (dig2_2),
    .dig2_3       (dig2_3),
    .disp_sel     (disp_sel),
    .sum_start    (sum_start),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sum_start) sum_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] op_a();
    return {4'h0, dig1_3, dig1_2, dig1_1};
  endfunction

  function automatic logic [15:0] op_b();
    return {4'h0, dig2_3, dig2_2, dig2_1};
  endfunction

  // One-cycle key pulse; returns at the falling edge after the accepting edge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    do_reset();

    check("reset_a", op_a(), 16'h0000);
    check("reset_b", op_b(), 16'h0000);
    check("reset_disp", {14'd0, disp_sel}, 16'd0);
    check("reset_start", {15'd0, sum_start}, 16'd0);
    check("reset_rv", {15'd0, result_valid}, 16'd0);

    press(4'd1); press(4'd2); press(4'd3);
    check("entry_123", op_a(), 16'h0123);
    check("entry_disp", {14'd0, disp_sel}, 16'd0);
    press(4'd4);
    check("entry_full", op_a(), 16'h0123);

    press(4'hC);
    press(4'd4); press(4'd5); press(4'hA);
    check("plus_disp", {14'd0, disp_sel}, 16'd1);
    check("plus_a", op_a(), 16'h0045);
    press(4'd6); press(4'd7); press(4'd8);
    check("entry_b", op_b(), 16'h0678);

    sum_base = sum_cnt;
    press(4'hB);
    check("eq_start", {15'd0, sum_start}, 16'd1);
    check("eq_rv", {15'd0, result_valid}, 16'd1);
    check("eq_disp", {14'd0, disp_sel}, 16'd2);
    @(negedge clk);
    check("eq_start_drop", {15'd0, sum_start}, 16'd0);
    check("eq_rv_hold", {15'd0, result_valid}, 16'd1);
    check("eq_pulses", 16'(sum_cnt - sum_base), 16'd1);

    press(4'hA);
    check("res_plus_disp", {14'd0, disp_sel}, 16'd2);
    press(4'hB);
    check("res_eq_start", {15'd0, sum_start}, 16'd0);
    check("res_eq_disp", {14'd0, disp_sel}, 16'd2);
    press(4'hE);
    check("res_hold_a", op_a(), 16'h0045);
    check("res_hold_b", op_b(), 16'h0678);

    press(4'd7);
    check("res_dig_a", op_a(), 16'h0007);
    check("res_dig_b", op_b(), 16'h0000);
    check("res_dig_disp", {14'd0, disp_sel}, 16'd0);
    check("res_dig_rv", {15'd0, result_valid}, 16'd0);
    press(4'd1);
    check("res_dig_count", op_a(), 16'h0071);

    press(4'hC);
    press(4'd9); press(4'd9); press(4'hA); press(4'd5);
    check("mid_b", op_b(), 16'h0005);
    press(4'hC);
    check("clr_a", op_a(), 16'h0000);
    check("clr_b", op_b(), 16'h0000);
    check("clr_disp", {14'd0, disp_sel}, 16'd0);

    press(4'd1);
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd3;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    check("rst_key_a", op_a(), 16'h0000);
    check("rst_key_disp", {14'd0, disp_sel}, 16'd0);

    sum_base = sum_cnt;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd9;
    @(negedge clk) key_code = 4'd8;
    @(negedge clk) key_code = 4'hA;
    @(negedge clk) key_code = 4'hB;
    @(negedge clk) key_valid = 1'b0;
    check("b2b_a", op_a(), 16'h0098);
    check("b2b_b", op_b(), 16'h0000);
    check("b2b_disp", {14'd0, disp_sel}, 16'd2);
    check("b2b_rv", {15'd0, result_valid}, 16'd1);
    repeat (2) @(negedge clk);
    check("b2b_pulses", 16'(sum_cnt - sum_base), 16'd1);

    press(4'hC);
    press(4'd1); press(4'd2); press(4'd3);
    press(4'hD);
`ifdef OPERAND_BACKSPACE_EN
    check("bs_one", op_a(), 16'h0012);
`else
    check("bs_one", op_a(), 16'h0123);
`endif
    press(4'hD); press(4'hD); press(4'hD);
    check("bs_disp", {14'd0, disp_sel}, 16'd0);
    press(4'd5);
`ifdef OPERAND_BACKSPACE_EN
    check("bs_empty", op_a(), 16'h0005);
`else
    check("bs_empty", op_a(), 16'h0123);
`endif

    check("total_pulses", 16'(sum_cnt), 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Control FSM that turns decoded keypad events into the two 3-digit BCD operands feeding the BCD adder, and tells the display multiplexer whether to show operand A, operand B or the sum. It sits between the keypad scanner/decoder and the adder/display path. It owns all entry state: digit shifting, operand switching, result request and clear.

## Interface
- No parameters.
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `key_valid` in 1 — one-cycle pulse per debounced key press.
- `key_code` in 4 — key code, valid when `key_valid`=1:
  - 0–9: digit
  - 0xA: next operand (`+`)
  - 0xB: equals
  - 0xC: clear
  - 0xD: backspace
  - 0xE–0xF: unused
- `dig1_1`, `dig1_2`, `dig1_3` out 4 each — operand A units, tens, hundreds (BCD).
- `dig2_1`, `dig2_2`, `dig2_3` out 4 each — operand B units, tens, hundreds (BCD).
- `disp_sel` out 2 — display source: 0 = operand A, 1 = operand B, 2 = result; 3 is never driven.
- `sum_start` out 1 — one-cycle pulse when the result is requested.
- `result_valid` out 1 — high while in RESULT.

## Operation
- States:
  - ENTRY_A: editing operand A; `disp_sel`=0.
  - ENTRY_B: editing operand B; `disp_sel`=1.
  - RESULT: showing the sum; `disp_sel`=2, `result_valid`=1.
- Digit entry (ENTRY_A / ENTRY_B):
  - A digit key loads the active operand as a left shift: hundreds←tens, tens←units, units←key.
  - The per-operand digit count increments, saturating at 3.
  - A digit key when the count is already 3 is ignored and the operand is unchanged.
- Key 0xA:
  - In ENTRY_A: go to ENTRY_B. This is allowed with 0 digits entered; A stays 000.
  - In ENTRY_B and RESULT: ignored.
- Key 0xB:
  - In ENTRY_B: go to RESULT and pulse `sum_start`. This is allowed with 0 B digits; B = 000.
  - In ENTRY_A and RESULT: ignored.
- Key 0xC, any state: clear both operands and both counts, go to ENTRY_A.
- Digit key in RESULT:
  - Clear both operands and counts.
  - Load the digit as A units with count_A=1.
  - Go to ENTRY_A.
- Key 0xD: see Configuration. Keys 0xE and 0xF are ignored in every state.
- Operands are held stable in RESULT, so the combinational adder output stays valid.

## Timing
- Reset values:
  - State ENTRY_A, all `dig*` = 0, counts = 0.
  - `disp_sel`=0, `sum_start`=0, `result_valid`=0.
- All outputs are registered. A key sampled at edge N is reflected on the outputs after edge N; latency is 1 cycle.
- `sum_start` is high for exactly the one cycle following the accepting edge, coincident with the first cycle of `result_valid`=1.
- `rst` has priority over `key_valid` on the same edge: the key is dropped.
- Back-to-back `key_valid` on consecutive cycles must be handled. Each pulse is processed independently, with no lost keys.
- With `key_valid`=0, no state, operand or count changes.

## Configuration
- Macro `OPERAND_BACKSPACE_EN`, when defined:
  - Key 0xD in ENTRY_A/ENTRY_B shifts the active operand right (units←tens, tens←hundreds, hundreds←0) and decrements its count.
  - With count 0 the key is a no-op. It never changes state.
  - In RESULT, 0xD is ignored.
- When not defined: 0xD is ignored everywhere, and the backspace logic is not synthesized.

## Structure
- Shared package `calc_pkg`:
  - Key code constants (`KEY_PLUS`, `KEY_EQ`, `KEY_CLR`, `KEY_BS`).
  - State enum (ENTRY_A, ENTRY_B, RESULT).
  - `disp_sel` encoding constants, shared with the display multiplexer.
- Sub-module `bcd_operand_reg`, instantiated twice (A and B):
  - Holds 3 BCD digits plus a 2-bit count.
  - Inputs: `clr`, `shift_in` with digit, and `shift_out` (backspace).
  - Exports digits and `full`.
- The FSM in `operand_sequencer` only decodes keys and drives the per-instance strobes.

## Test plan
- Reset, then keys 1,2,3 → `dig1_3..1`=1,2,3; `disp_sel`=0; a fourth key 4 leaves 123.
- A=45, 0xA, B=678, 0xB → `dig2_*`=6,7,8; `sum_start` is a single 1-cycle pulse; `result_valid`=1; `disp_sel`=2.
- In RESULT, key 7 → A=007, B=000, ENTRY_A, `disp_sel`=0. In RESULT, 0xA or 0xB → no change.
- 0xC mid-entry in ENTRY_B with A=99, B=5 → all digits 0, ENTRY_A. `rst` on the same edge as a digit key → digit dropped, reset values.
- Keys on consecutive cycles (9,8 then 0xA then 0xB) → A=098, B=000, RESULT, with exactly one `sum_start`.
- With `OPERAND_BACKSPACE_EN`: A=123, 0xD → 012; 0xD ×3 more → 000, count stays 0, still ENTRY_A. Without the macro: 0xD → no change.
